// File: rtl/cpureg_ind_engine.sv
// CPU-side hold-word engine: stages wide data in 32-bit hold words and launches one
// indirect read or write on the wide expansion bus per GO, with timeout and auto-increment.
module cpureg_ind_engine #(
    parameter int BUSWIDTH = 128,
    parameter int NWORD    = 4,
    parameter int LAW      = 3,
    parameter int ADDRW    = 16,
    parameter int TOUT     = 255,
    parameter int TOUTW    = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                upen,
    input  logic [LAW-1:0]      upa,
    input  logic                upws,
    input  logic                uprs,
    input  logic [31:0]         updi,
    output logic                uprdy,
    output logic [31:0]         updo,
    output logic [ADDRW-1:0]    eaddr,
    output logic [BUSWIDTH-1:0] ewdata,
    output logic                ewr_req,
    output logic                erd_req,
    input  logic                erdy,
    input  logic [BUSWIDTH-1:0] erdata
);

    typedef enum logic [1:0] {IDLE, RWAIT, WWAIT} state_t;

    state_t              state_q, state_d;
    logic [BUSWIDTH-1:0] hold_q;
    logic [ADDRW-1:0]    eaddr_q;
    logic                ainc_q;
    logic                terr_q;
    logic [TOUTW-1:0]    cnt_q;

    logic                busy;
    logic                cpu_wr;
    logic                ctrl_wr;
    logic                go;
    logic                tout_hit;
    logic                done;
    logic                expire;
    logic                hold_wr_en;
    logic [NWORD*32-1:0] hold_pad;
    logic [NWORD*32-1:0] hold_wr;
    logic [31:0]         status;

    assign busy       = (state_q != IDLE);
    assign cpu_wr     = upen & upws;
    assign ctrl_wr    = cpu_wr & (upa == '0) & ~busy;
    assign go         = ctrl_wr & updi[31];
    assign tout_hit   = (cnt_q == TOUTW'(TOUT - 1));
    // erdy on the terminal-count cycle wins over the timeout
    assign done       = busy & erdy;
    assign expire     = busy & ~erdy & tout_hit;
    assign hold_wr_en = cpu_wr & ~busy & (upa != '0) & (upa <= LAW'(NWORD));
    assign hold_pad   = (NWORD*32)'(hold_q);

    always_comb begin
        hold_wr = hold_pad;
        for (int k = 0; k < NWORD; k++) begin
            if (upa == LAW'(k + 1)) hold_wr[k*32 +: 32] = updi;
        end
    end

    always_comb begin
        status            = '0;
        status[ADDRW-1:0] = eaddr_q;
        status[31]        = busy;
        status[30]        = terr_q;
        status[29]        = ainc_q;
    end

    always_comb begin
        updo = '0;
        if (upen && uprs) begin
            if (upa == '0) updo = status;
            for (int k = 0; k < NWORD; k++) begin
                if (upa == LAW'(k + 1)) updo = hold_pad[k*32 +: 32];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:         if (go) state_d = updi[30] ? RWAIT : WWAIT;
            RWAIT, WWAIT: if (erdy || tout_hit) state_d = IDLE;
            default:      state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            hold_q  <= '0;
            eaddr_q <= '0;
            ainc_q  <= 1'b0;
            terr_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (ctrl_wr) begin
                eaddr_q <= updi[ADDRW-1:0];
                ainc_q  <= updi[29];
            end else if (done && ainc_q) begin
                eaddr_q <= eaddr_q + ADDRW'(1);
            end
            if (go)          terr_q <= 1'b0;
            else if (expire) terr_q <= 1'b1;
            if (go)        cnt_q <= '0;
            else if (busy) cnt_q <= cnt_q + TOUTW'(1);
            if (state_q == RWAIT && erdy) hold_q <= erdata;
            else if (hold_wr_en)          hold_q <= hold_wr[BUSWIDTH-1:0];
        end
    end

    // updi bits between the address field and AINC have no meaning
    logic unused_ok;
    generate
        if (NWORD*32 > BUSWIDTH) begin : g_pad
            assign unused_ok = ^{updi[28:ADDRW], hold_wr[NWORD*32-1:BUSWIDTH]};
        end else begin : g_nopad
            assign unused_ok = ^updi[28:ADDRW];
        end
    endgenerate

    assign uprdy   = upen & (upws | uprs);
    assign eaddr   = eaddr_q;
    assign ewdata  = hold_q;
    assign ewr_req = (state_q == WWAIT);
    assign erd_req = (state_q == RWAIT);

endmodule

// File: tb/tb_cpureg_ind_engine.sv
// Directed bench for cpureg_ind_engine: CPU reads are scored through an expected queue,
// expansion-side behaviour is checked directly against hand-computed values.
module tb_cpureg_ind_engine;

    logic         clk;
    logic         rst_n;
    logic         upen;
    logic [2:0]   upa;
    logic         upws;
    logic         uprs;
    logic [31:0]  updi;
    logic         uprdy;
    logic [31:0]  updo;
    logic [15:0]  eaddr;
    logic [127:0] ewdata;
    logic         ewr_req;
    logic         erd_req;
    logic         erdy;
    logic [127:0] erdata;

    logic [31:0] exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [127:0] WDATA = 128'h44444444_33333333_22222222_11111111;
    localparam logic [127:0] RDATA = 128'hDEADBEEF_CAFEF00D_01234567_89ABCDEF;

    cpureg_ind_engine #(
        .BUSWIDTH(128), .NWORD(4), .LAW(3), .ADDRW(16), .TOUT(255), .TOUTW(8)
    ) dut (
        .clk(clk), .rst_n(rst_n), .upen(upen), .upa(upa), .upws(upws), .uprs(uprs),
        .updi(updi), .uprdy(uprdy), .updo(updo), .eaddr(eaddr), .ewdata(ewdata),
        .ewr_req(ewr_req), .erd_req(erd_req), .erdy(erdy), .erdata(erdata)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // monitor: every CPU read presented to the DUT pops one expected value
    always @(negedge clk) begin
        if (upen && uprs) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL rd_unexpected: got %0h expected none", updo);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                if (updo !== e || uprdy !== 1'b1) begin
                    n_fail++;
                    $display("FAIL rd_a%0d: got %0h rdy %0b expected %0h rdy 1", upa, updo, uprdy, e);
                end
            end
        end
    end

    // driver tasks: entered and left at posedge+1
    task automatic cpu_write(input logic [2:0] a, input logic [31:0] d);
        upen = 1'b1; upws = 1'b1; upa = a; updi = d;
        #2 check("wr_uprdy", {127'd0, uprdy}, 128'd1);
        @(posedge clk); #1;
        upen = 1'b0; upws = 1'b0; updi = '0;
    endtask

    task automatic cpu_read(input logic [2:0] a, input logic [31:0] exp);
        exp_q.push_back(exp);
        upen = 1'b1; uprs = 1'b1; upa = a;
        @(posedge clk); #1;
        upen = 1'b0; uprs = 1'b0;
    endtask

    // counts request cycles; pulses erdy on request cycle erdy_at (0 = never)
    task automatic run_req(input bit rd, input int erdy_at, input logic [127:0] rdata, output int n);
        int guard;
        n = 0;
        guard = 0;
        while ((rd ? erd_req : ewr_req) && guard < 1000) begin
            n++;
            guard++;
            if (n == erdy_at) begin
                erdy = 1'b1;
                erdata = rdata;
            end
            @(posedge clk); #1;
            erdy = 1'b0;
        end
        if (guard >= 1000) begin
            n_checks++;
            n_fail++;
            $display("FAIL req_timeout: got stuck request expected release");
        end
    endtask

    initial begin
        int n;
        rst_n = 1'b0; upen = 1'b0; upa = '0; upws = 1'b0; uprs = 1'b0;
        updi = '0; erdy = 1'b0; erdata = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ewr_req", {127'd0, ewr_req}, 128'd0);
        check("rst_erd_req", {127'd0, erd_req}, 128'd0);
        check("rst_eaddr", {112'd0, eaddr}, 128'd0);
        check("rst_ewdata", ewdata, 128'd0);
        check("rst_uprdy", {127'd0, uprdy}, 128'd0);
        check("rst_updo", {96'd0, updo}, 128'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // write transaction, erdy on third request cycle
        for (int k = 1; k <= 4; k++) cpu_write(3'(k), {8{4'(k)}});
        cpu_write(3'd0, 32'h80000012);
        check("wr_eaddr", {112'd0, eaddr}, 128'h12);
        check("wr_ewdata", ewdata, WDATA);
        run_req(1'b0, 3, '0, n);
        check("wr_req_cycles", 128'(n), 128'd3);
        cpu_read(3'd0, 32'h00000012);

        // read transaction
        cpu_write(3'd0, 32'hC0000020);
        run_req(1'b1, 1, RDATA, n);
        check("rd_req_cycles", 128'(n), 128'd1);
        cpu_read(3'd1, 32'h89ABCDEF);
        cpu_read(3'd2, 32'h01234567);
        cpu_read(3'd3, 32'hCAFEF00D);
        cpu_read(3'd4, 32'hDEADBEEF);
        cpu_read(3'd0, 32'h00000020);

        // timeout
        cpu_write(3'd0, 32'hC0000005);
        run_req(1'b1, 0, '0, n);
        check("tout_req_cycles", 128'(n), 128'd255);
        cpu_read(3'd0, 32'h40000005);
        cpu_read(3'd1, 32'h89ABCDEF);
        cpu_read(3'd4, 32'hDEADBEEF);

        // writes ignored while busy
        cpu_write(3'd0, 32'h80000040);
        cpu_write(3'd1, 32'hFFFFFFFF);
        cpu_write(3'd0, 32'h80000099);
        check("busy_eaddr", {112'd0, eaddr}, 128'h40);
        check("busy_ewdata", ewdata, RDATA);
        cpu_read(3'd0, 32'h80000040);
        run_req(1'b0, 1, '0, n);
        check("busy_req_cycles", 128'(n), 128'd1);
        cpu_read(3'd1, 32'h89ABCDEF);
        cpu_read(3'd0, 32'h00000040);

        // auto-increment with wrap, then no increment on timeout
        cpu_write(3'd0, 32'hA000FFFF);
        run_req(1'b0, 2, '0, n);
        check("ainc_req_cycles", 128'(n), 128'd2);
        cpu_read(3'd0, 32'h20000000);
        cpu_write(3'd0, 32'hE0000100);
        run_req(1'b1, 0, '0, n);
        check("ainc_tout_cycles", 128'(n), 128'd255);
        cpu_read(3'd0, 32'h60000100);

        // GO=0 updates address/AINC only, TERR kept; erdy while idle ignored
        cpu_write(3'd0, 32'h00000ABC);
        cpu_read(3'd0, 32'h40000ABC);
        erdy = 1'b1; erdata = {4{32'h5A5A5A5A}};
        @(posedge clk); #1;
        erdy = 1'b0;
        check("idle_erdy_ewdata", ewdata, RDATA);
        cpu_read(3'd0, 32'h40000ABC);

        // out-of-range address
        cpu_write(3'd5, 32'h12345678);
        cpu_read(3'd5, 32'h0);
        cpu_read(3'd7, 32'h0);
        check("oor_ewdata", ewdata, RDATA);

        // reset mid-transaction
        cpu_write(3'd0, 32'hC0000010);
        check("mid_erd_req", {127'd0, erd_req}, 128'd1);
        #1 rst_n = 1'b0;
        #1 check("rst_mid_erd_req", {127'd0, erd_req}, 128'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        cpu_read(3'd0, 32'h0);
        for (int k = 1; k <= 4; k++) cpu_read(3'(k), 32'h0);

        repeat (2) @(posedge clk);
        check("exp_q_drained", 128'(exp_q.size()), 128'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cpureg_ind_engine.md
Name: cpureg_ind_engine

Overview:
- Parametrised successor of the 32-bit CPU wide-register hold block.
- CPU stages data in NWORD 32-bit hold words, then writes a control word to launch one indirect read or write on an internal wide expansion bus.
- Adds addressed targets, a request/ready handshake with timeout, busy/error status and optional address auto-increment.
- Sits between the 32-bit CPU register decoder and the wide internal register banks.

Parameters:
- BUSWIDTH, 128: expansion data width; must be >32.
- NWORD, 4: hold words; must equal ceil(BUSWIDTH/32).
- LAW, 3: local address width; must satisfy 2^LAW >= NWORD+1.
- ADDRW, 16: expansion address width; must be <=29.
- TOUT, 255: timeout in clk cycles; must be >=1.
- TOUTW, 8: timeout counter width; must satisfy 2^TOUTW > TOUT.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset: asynchronous assertion, active-low.
- upen  in  1  block select, qualifies upws/uprs.
- upa  in  LAW  local word address: 0=CTRL/STATUS, k=hold word k-1 (k=1..NWORD).
- upws  in  1  CPU write strobe, 1 cycle.
- uprs  in  1  CPU read strobe, 1 cycle.
- updi  in  32  CPU write data.
- uprdy  out  1  CPU access ready.
- updo  out  32  CPU read data.
- eaddr  out  ADDRW  expansion target address.
- ewdata  out  BUSWIDTH  expansion write data.
- ewr_req  out  1  expansion write request (level).
- erd_req  out  1  expansion read request (level).
- erdy  in  1  expansion completion strobe.
- erdata  in  BUSWIDTH  expansion read data, valid with erdy.

Behaviour:
- Reset: every register clears to 0, so uprdy, updo, eaddr, ewdata, ewr_req and erd_req are all 0. FSM=IDLE. A reset mid-transaction aborts it and drops the request the same cycle.
- Local access: uprdy = upen & (upws|uprs), combinational, zero wait.
  - updo is combinational: STATUS or hold word when upen & uprs; otherwise 0.
  - Out-of-range upa (>NWORD): write ignored, read returns 0, uprdy still asserted.
- CTRL write fields: bit31 GO, bit30 RD (1=read, 0=write), bit29 AINC, bits[ADDRW-1:0] address.
- STATUS read fields: bit31 BUSY, bit30 TERR (timeout error), bit29 AINC, bits[ADDRW-1:0] current eaddr. Other bits read 0.
- Hold words: ewdata = hold[BUSWIDTH-1:0]. Hold-word bits above BUSWIDTH are not stored and read 0.
- While BUSY, CPU writes to CTRL or hold words are ignored (uprdy still asserted). Reads are always allowed.
- FSM:
  - IDLE: a CTRL write with GO=1 latches eaddr, AINC and RD; clears TERR and the timeout counter; then
    - RD=1: next cycle erd_req=1, state RWAIT.
    - RD=0: next cycle ewr_req=1, state WWAIT.
  - A CTRL write with GO=0 in IDLE updates only eaddr and AINC.
  - RWAIT/WWAIT: request held high and counter increments every cycle.
    - On erdy: request drops next cycle, return to IDLE. In RWAIT, hold <= erdata on the same edge.
    - If counter reaches TOUT-1 without erdy: request drops, TERR=1, IDLE. Hold is unchanged.
    - erdy in the same cycle as the terminal count counts as success and TERR stays 0.
  - BUSY = (state != IDLE).
  - Transaction latency: first request cycle follows the GO write by 1 clk. Return to IDLE is 1 clk after erdy.
- Auto-increment: after a successful completion with AINC=1, eaddr <= eaddr+1, wrapping mod 2^ADDRW. There is no increment on timeout.
- erdy while IDLE is ignored.

Test Plan:
- Write: write hold1..4 = 0x11111111..0x44444444; CTRL=0x80000012; erdy on the 3rd request cycle -> ewr_req high exactly 3 cycles; eaddr=0x0012; ewdata=0x44444444_33333333_22222222_11111111; STATUS then reads 0x00000012.
- Read: CTRL=0xC0000020; erdata=0xDEADBEEF_CAFEF00D_01234567_89ABCDEF with erdy -> hold1 reads 0x89ABCDEF, hold4 reads 0xDEADBEEF; BUSY=0.
- Timeout: CTRL=0xC0000005 with no erdy, TOUT=255 -> erd_req high 255 cycles; then STATUS=0x40000005; hold words unchanged.
- Busy protection: during WWAIT write hold1=0xFFFFFFFF and CTRL=0x80000099 -> both ignored; uprdy=1; ewdata and eaddr stable.
- Auto-increment and wrap: ADDRW=16, CTRL=0xA000FFFF, then complete -> STATUS address 0x0000; after a timeout with AINC, address is unchanged.
- Reset mid-transaction: assert rst_n=0 during RWAIT -> erd_req drops immediately; STATUS=0; all hold words=0.
